// File: rtl/tbu_byte_sched.sv
// Ping-pong bit-to-byte scheduler between the traceback unit and a byte consumer.
// Each block arrives newest-bit-first and is read out oldest-byte-first over valid/ready.
module tbu_byte_sched #(
  parameter int BLK_BITS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tbu_bit_i,
  input  logic       tbu_valid_i,
  output logic       tbu_ready_o,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  input  logic       byte_ready_i,
  output logic       byte_last_o,
  output logic       ovf_o
);

  localparam int NBYTES = BLK_BITS / 8;
  localparam int IW     = $clog2(BLK_BITS);
  localparam int RW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(BLK_BITS - 1);
  localparam logic [RW-1:0] RB_LAST = RW'(NBYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [BLK_BITS-1:0] bank_q [2];
  logic [1:0]          full_q;
  logic                wr_bank_q;
  logic                rd_bank_q;
  logic [IW-1:0]       wr_idx_q;
  logic [RW-1:0]       rd_byte_q;
  state_t              state_q, state_d;

  logic          wr_acc;
  logic          wr_done;
  logic          load_first;
  logic          load_next;
  logic          rd_release;
  logic [RW-1:0] rd_byte_nxt;
  logic [7:0]    nxt_byte;

  assign tbu_ready_o = !full_q[wr_bank_q];
  assign wr_acc      = tbu_valid_i && tbu_ready_o;
  assign wr_done     = wr_acc && (wr_idx_q == '0);

  // Byte k of the bank holds bits 8k..8k+7 with the oldest bit at the LSB.
  assign rd_byte_nxt = load_first ? '0 : rd_byte_q + RW'(1);
  assign nxt_byte    = 8'(bank_q[rd_bank_q] >> {rd_byte_nxt, 3'b000});

  always_comb begin
    state_d    = state_q;
    load_first = 1'b0;
    load_next  = 1'b0;
    rd_release = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          load_first = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (byte_ready_i) begin
          if (rd_byte_q == RB_LAST) begin
            rd_release = 1'b1;
            state_d    = IDLE;
          end else begin
            load_next = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Storage carries no reset: the full flags alone decide what is readable.
  always_ff @(posedge clk) begin
    if (wr_acc) bank_q[wr_bank_q][wr_idx_q] <= tbu_bit_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_idx_q     <= IDX_TOP;
      rd_byte_q    <= '0;
      byte_o       <= '0;
      byte_valid_o <= 1'b0;
      byte_last_o  <= 1'b0;
      ovf_o        <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_idx_q <= wr_done ? IDX_TOP : wr_idx_q - IW'(1);
        if (wr_done) wr_bank_q <= !wr_bank_q;
      end
      // A completing write and a release always target different banks.
      if (wr_done)    full_q[wr_bank_q] <= 1'b1;
      if (rd_release) full_q[rd_bank_q] <= 1'b0;
      if (tbu_valid_i && !tbu_ready_o) ovf_o <= 1'b1;

      if (load_first || load_next) begin
        byte_o       <= nxt_byte;
        byte_valid_o <= 1'b1;
        byte_last_o  <= (rd_byte_nxt == RB_LAST);
        rd_byte_q    <= rd_byte_nxt;
      end else if (rd_release) begin
        byte_valid_o <= 1'b0;
        byte_last_o  <= 1'b0;
        rd_bank_q    <= !rd_bank_q;
      end
    end
  end

endmodule

// File: tb/tb_tbu_byte_sched.sv
// Directed bench for tbu_byte_sched: 32-bit blocks on one instance, 8-bit blocks on another.
module tb_tbu_byte_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       tbu_bit, tbu_valid, tbu_ready;
  logic [7:0] byte_dat;
  logic       byte_valid, byte_ready, byte_last, ovf;

  logic       t8_bit, t8_valid, t8_ready;
  logic [7:0] b8_dat;
  logic       b8_valid, b8_ready, b8_last, ovf8;

  int errors = 0;
  int checks = 0;

  tbu_byte_sched #(.BLK_BITS(32)) dut (
    .clk(clk), .rst(rst),
    .tbu_bit_i(tbu_bit), .tbu_valid_i(tbu_valid), .tbu_ready_o(tbu_ready),
    .byte_o(byte_dat), .byte_valid_o(byte_valid), .byte_ready_i(byte_ready),
    .byte_last_o(byte_last), .ovf_o(ovf)
  );

  tbu_byte_sched #(.BLK_BITS(8)) dut8 (
    .clk(clk), .rst(rst),
    .tbu_bit_i(t8_bit), .tbu_valid_i(t8_valid), .tbu_ready_o(t8_ready),
    .byte_o(b8_dat), .byte_valid_o(b8_valid), .byte_ready_i(b8_ready),
    .byte_last_o(b8_last), .ovf_o(ovf8)
  );

  task automatic push_bit(input logic b);
    tbu_bit = b; tbu_valid = 1'b1;
    @(posedge clk); #1;
    tbu_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] d);
    for (int i = 31; i >= 0; i--) push_bit(d[i]);
  endtask

  task automatic send8(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      t8_bit = d[i]; t8_valid = 1'b1;
      @(posedge clk); #1;
      t8_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (byte_dat !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", byte_dat); end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", byte_valid); end
    checks++; if (byte_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", byte_last); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    checks++; if (tbu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", tbu_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] d;
    d = 32'h44332211;
    byte_ready = 1'b1;
    send32(d);
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL single_latency_early: got %b want 0", byte_valid); end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (byte_valid !== 1'b1 || byte_dat !== d[8*k +: 8] || byte_last !== (k == 3)) begin
        errors++; $display("FAIL single_byte%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", k, byte_valid, byte_dat, byte_last, d[8*k +: 8], (k == 3));
      end
      @(posedge clk); #1;
    end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL single_end_valid: got %b want 0", byte_valid); end
  endtask

  task automatic test_backpressure();
    byte_ready = 1'b0;
    send32(32'h88776655);
    @(posedge clk); #1;
    checks++; if (byte_valid !== 1'b1 || byte_dat !== 8'h55) begin errors++; $display("FAIL bp_first: got v=%b d=%h want v=1 d=55", byte_valid, byte_dat); end
    byte_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (byte_dat !== 8'h66) begin errors++; $display("FAIL bp_byte1: got %h want 66", byte_dat); end
    @(posedge clk); #1;
    byte_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (byte_valid !== 1'b1 || byte_dat !== 8'h77 || byte_last !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b d=%h l=%b want v=1 d=77 l=0", c, byte_valid, byte_dat, byte_last);
      end
      @(posedge clk); #1;
    end
    byte_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (byte_valid !== 1'b1 || byte_dat !== 8'h88 || byte_last !== 1'b1) begin errors++; $display("FAIL bp_last: got v=%b d=%h l=%b want v=1 d=88 l=1", byte_valid, byte_dat, byte_last); end
    @(posedge clk); #1;
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid: got %b want 0", byte_valid); end
  endtask

  task automatic test_pingpong();
    logic [63:0] d;
    d = 64'h08070605_04030201;
    byte_ready = 1'b0;
    send32(d[31:0]);
    send32(d[63:32]);
    checks++; if (tbu_ready !== 1'b0) begin errors++; $display("FAIL pp_ready_low: got %b want 0", tbu_ready); end
    push_bit(1'b1);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL pp_ovf: got %b want 1", ovf); end
    byte_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL pp_idle: got %b want 0", byte_valid); end
        @(posedge clk); #1;
      end
      checks++; if (byte_valid !== 1'b1 || byte_dat !== d[8*k +: 8] || byte_last !== (k % 4 == 3)) begin
        errors++; $display("FAIL pp_byte%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", k, byte_valid, byte_dat, byte_last, d[8*k +: 8], (k % 4 == 3));
      end
      @(posedge clk); #1;
    end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL pp_end_valid: got %b want 0", byte_valid); end
    checks++; if (tbu_ready !== 1'b1) begin errors++; $display("FAIL pp_ready_back: got %b want 1", tbu_ready); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL pp_ovf_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] a, b;
    a = 32'h1D1C1B1A;
    b = 32'h2D2C2B2A;
    byte_ready = 1'b0;
    send32(a);
    for (int i = 31; i >= 0; i--) begin
      byte_ready = (i < 4);
      if (i < 4) begin
        checks++; if (byte_valid !== 1'b1 || byte_dat !== a[8*(3-i) +: 8]) begin
          errors++; $display("FAIL sim_a_byte%0d: got v=%b d=%h want v=1 d=%h", 3 - i, byte_valid, byte_dat, a[8*(3-i) +: 8]);
        end
      end
      push_bit(b[i]);
    end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL sim_idle: got %b want 0", byte_valid); end
    checks++; if (tbu_ready !== 1'b1) begin errors++; $display("FAIL sim_ready: got %b want 1", tbu_ready); end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (byte_valid !== 1'b1 || byte_dat !== b[8*k +: 8] || byte_last !== (k == 3)) begin
        errors++; $display("FAIL sim_b_byte%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", k, byte_valid, byte_dat, byte_last, b[8*k +: 8], (k == 3));
      end
      @(posedge clk); #1;
    end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL sim_end_valid: got %b want 0", byte_valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    d = 32'hA1B2C3D4;
    byte_ready = 1'b0;
    for (int i = 0; i < 13; i++) push_bit(1'b1);
    rst = 1'b1;
    #2;
    checks++; if (ovf !== 1'b0 || tbu_ready !== 1'b1 || byte_valid !== 1'b0) begin
      errors++; $display("FAIL rm_partial: got ovf=%b rdy=%b v=%b want 0 1 0", ovf, tbu_ready, byte_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send32(32'h0C0B0A09);
    @(posedge clk); #1;
    checks++; if (byte_valid !== 1'b1 || byte_dat !== 8'h09) begin errors++; $display("FAIL rm_first: got v=%b d=%h want v=1 d=09", byte_valid, byte_dat); end
    byte_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (byte_dat !== 8'h0A) begin errors++; $display("FAIL rm_second: got %h want 0a", byte_dat); end
    byte_ready = 1'b0;
    rst = 1'b1;
    #2;
    checks++; if (byte_valid !== 1'b0 || byte_dat !== 8'h00 || byte_last !== 1'b0 || tbu_ready !== 1'b1) begin
      errors++; $display("FAIL rm_send: got v=%b d=%h l=%b rdy=%b want 0 00 0 1", byte_valid, byte_dat, byte_last, tbu_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    byte_ready = 1'b1;
    send32(d);
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL rm_after_early: got %b want 0", byte_valid); end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (byte_valid !== 1'b1 || byte_dat !== d[8*k +: 8] || byte_last !== (k == 3)) begin
        errors++; $display("FAIL rm_byte%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", k, byte_valid, byte_dat, byte_last, d[8*k +: 8], (k == 3));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_blk8();
    b8_ready = 1'b1;
    send8(8'hA5);
    @(posedge clk); #1;
    checks++; if (b8_valid !== 1'b1 || b8_dat !== 8'hA5 || b8_last !== 1'b1) begin errors++; $display("FAIL b8_first: got v=%b d=%h l=%b want 1 a5 1", b8_valid, b8_dat, b8_last); end
    @(posedge clk); #1;
    checks++; if (b8_valid !== 1'b0) begin errors++; $display("FAIL b8_gap: got %b want 0", b8_valid); end
    send8(8'h3C);
    @(posedge clk); #1;
    checks++; if (b8_valid !== 1'b1 || b8_dat !== 8'h3C || b8_last !== 1'b1) begin errors++; $display("FAIL b8_second: got v=%b d=%h l=%b want 1 3c 1", b8_valid, b8_dat, b8_last); end
    @(posedge clk); #1;
    b8_ready = 1'b0;
    send8(8'h11);
    send8(8'h22);
    checks++; if (t8_ready !== 1'b0) begin errors++; $display("FAIL b8_full: got %b want 0", t8_ready); end
    b8_ready = 1'b1;
    checks++; if (b8_valid !== 1'b1 || b8_dat !== 8'h11 || b8_last !== 1'b1) begin errors++; $display("FAIL b8_pp0: got v=%b d=%h l=%b want 1 11 1", b8_valid, b8_dat, b8_last); end
    @(posedge clk); #1;
    checks++; if (b8_valid !== 1'b0) begin errors++; $display("FAIL b8_pp_idle: got %b want 0", b8_valid); end
    @(posedge clk); #1;
    checks++; if (b8_valid !== 1'b1 || b8_dat !== 8'h22 || b8_last !== 1'b1) begin errors++; $display("FAIL b8_pp1: got v=%b d=%h l=%b want 1 22 1", b8_valid, b8_dat, b8_last); end
    @(posedge clk); #1;
    checks++; if (b8_valid !== 1'b0 || t8_ready !== 1'b1 || ovf8 !== 1'b0) begin errors++; $display("FAIL b8_end: got v=%b rdy=%b ovf=%b want 0 1 0", b8_valid, t8_ready, ovf8); end
  endtask

  initial begin
    rst = 1'b1;
    tbu_bit = 1'b0; tbu_valid = 1'b0; byte_ready = 1'b0;
    t8_bit = 1'b0; t8_valid = 1'b0; b8_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_pingpong();
    test_simultaneous();
    test_reset_mid();
    test_blk8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
